// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and opcodes used by fetch, hazard detection and decode
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0] OPC_HLT = 4'b1111;
  localparam logic [3:0] OPC_B   = 4'b1100;
  localparam logic [3:0] OPC_BR  = 4'b1101;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4] == OPC_HLT;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  // Holds at all-ones so the counter never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage controller: PC, IF/ID register, halt flag and stall/flush counters
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write_en,
  input  logic               ifid_write_en,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [2:0] ACT_HALT  = 3'd0;
  localparam logic [2:0] ACT_STALL = 3'd1;
  localparam logic [2:0] ACT_FLUSH = 3'd2;
  localparam logic [2:0] ACT_HLT   = 3'd3;
  localparam logic [2:0] ACT_RUN   = 3'd4;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  pc_plus2;
  logic [ADDR_W-1:0]  target_aligned;
  logic [INSTR_W-1:0] instr_next;
  logic [ADDR_W-1:0]  pp2_next;
  logic               valid_next;
  logic               halted_next;
  logic               hlt_fetch;
  logic               stall;
  logic               stall_inc;
  logic               flush_inc;
  logic [2:0]         act;

  assign imem_addr      = pc;
  assign pc_plus2       = pc + ADDR_W'(2);
  assign target_aligned = {branch_target[ADDR_W-1:1], 1'b0};
  assign hlt_fetch      = is_hlt(imem_data);

  // PC moving while IF/ID holds is not a legal request; it degrades to a stall.
  assign stall = !pc_write_en || !ifid_write_en;

  always_comb begin
    act = ACT_RUN;
    if (halted) begin
      act = ACT_HALT;
    end else if (stall) begin
      act = ACT_STALL;
    end else if (branch_taken) begin
      act = ACT_FLUSH;
    end else if (hlt_fetch) begin
      act = ACT_HLT;
    end
  end

  always_comb begin
    pc_next     = pc;
    instr_next  = ifid_instr;
    pp2_next    = ifid_pc_plus2;
    valid_next  = ifid_valid;
    halted_next = halted;
    case (act)
      ACT_HALT: begin
        if (ifid_write_en) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end
      end
      ACT_STALL: begin
        pc_next = pc;
      end
      ACT_FLUSH: begin
        // Wrong-path fetch (possibly a HLT) is dropped, never latched.
        pc_next    = target_aligned;
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
      ACT_HLT: begin
        instr_next  = imem_data;
        pp2_next    = pc_plus2;
        valid_next  = 1'b1;
        halted_next = 1'b1;
      end
      default: begin
        pc_next    = pc_plus2;
        instr_next = imem_data;
        pp2_next   = pc_plus2;
        valid_next = 1'b1;
      end
    endcase
  end

  assign stall_inc = (act == ACT_STALL) && !pc_write_en;
  assign flush_inc = (act == ACT_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
      halted        <= 1'b0;
    end else begin
      pc            <= pc_next;
      ifid_instr    <= instr_next;
      ifid_pc_plus2 <= pp2_next;
      ifid_valid    <= valid_next;
      halted        <= halted_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  a_no_pc_write_without_ifid: assert property (
    @(posedge clk) disable iff (!rst_n) !(pc_write_en && !ifid_write_en)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed bench for fetch_ctrl with a word-addressed instruction memory
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic [15:0] s_imem_addr;
  logic [15:0] s_ifid_instr;
  logic [15:0] s_ifid_pc_plus2;
  logic        s_ifid_valid;
  logic        s_halted;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_flush_cnt;

  logic [15:0] mem [0:32767];
  int vectors = 0;
  int errors  = 0;

  assign imem_data = mem[imem_addr[15:1]];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Narrow-counter instance on the same inputs, so saturation is reachable in a few cycles.
  fetch_ctrl #(.CNT_W(4)) dut_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (s_imem_addr),
    .ifid_instr    (s_ifid_instr),
    .ifid_pc_plus2 (s_ifid_pc_plus2),
    .ifid_valid    (s_ifid_valid),
    .halted        (s_halted),
    .stall_cnt     (s_stall_cnt),
    .flush_cnt     (s_flush_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = {4'h2, 12'(i)};
    rst_n = 1'b0;
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    tick();
    rst_n = 1'b1;

    // T1 reset state and first fetches
    check("t1_addr", imem_addr, 16'h0000);
    check("t1_valid", {15'd0, ifid_valid}, 16'h0000);
    check("t1_halted", {15'd0, halted}, 16'h0000);
    check("t1_stall", stall_cnt, 16'h0000);
    tick();
    check("t1_addr2", imem_addr, 16'h0002);
    check("t1_instr0", ifid_instr, 16'h2000);
    check("t1_pp2_0", ifid_pc_plus2, 16'h0002);
    check("t1_valid1", {15'd0, ifid_valid}, 16'h0001);
    tick();
    check("t1_addr4", imem_addr, 16'h0004);
    tick();
    check("t1_addr6", imem_addr, 16'h0006);

    // T2 load-use stall at 0006
    pc_write_en = 1'b0;
    ifid_write_en = 1'b0;
    tick();
    check("t2_addr_hold", imem_addr, 16'h0006);
    check("t2_instr_hold", ifid_instr, 16'h2002);
    check("t2_pp2_hold", ifid_pc_plus2, 16'h0006);
    check("t2_stall_cnt", stall_cnt, 16'h0001);
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    tick();
    check("t2_resume_addr", imem_addr, 16'h0008);
    check("t2_resume_instr", ifid_instr, 16'h2003);
    tick(4);
    check("t3_pre_addr", imem_addr, 16'h0010);

    // T3 taken branch, odd target gets aligned
    branch_taken = 1'b1;
    branch_target = 16'h0041;
    tick();
    branch_taken = 1'b0;
    check("t3_addr", imem_addr, 16'h0040);
    check("t3_valid", {15'd0, ifid_valid}, 16'h0000);
    check("t3_flush_cnt", flush_cnt, 16'h0001);
    tick();
    check("t3_instr", ifid_instr, 16'h2020);
    check("t3_pp2", ifid_pc_plus2, 16'h0042);
    check("t3_addr2", imem_addr, 16'h0042);

    // T4 stall and branch together; stall wins, then branch re-presented
    pc_write_en = 1'b0;
    ifid_write_en = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'h0080;
    tick();
    check("t4_addr_hold", imem_addr, 16'h0042);
    check("t4_flush_hold", flush_cnt, 16'h0001);
    check("t4_stall_cnt", stall_cnt, 16'h0002);
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("t4_addr_taken", imem_addr, 16'h0080);
    check("t4_flush_cnt", flush_cnt, 16'h0002);
    check("t4_valid", {15'd0, ifid_valid}, 16'h0000);

    // Mid-run asynchronous reset, observed without a clock edge
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    check("rst_stall", stall_cnt, 16'h0000);
    check("rst_flush", flush_cnt, 16'h0000);
    rst_n = 1'b1;

    // T5 halt at 000C
    mem[16'h000C >> 1] = 16'hF000;
    tick(6);
    check("t5_addr_pre", imem_addr, 16'h000C);
    tick();
    check("t5_instr", ifid_instr, 16'hF000);
    check("t5_valid", {15'd0, ifid_valid}, 16'h0001);
    check("t5_pp2", ifid_pc_plus2, 16'h000E);
    check("t5_halted", {15'd0, halted}, 16'h0001);
    check("t5_addr", imem_addr, 16'h000C);
    tick();
    check("t5_nop", ifid_instr, 16'h0000);
    check("t5_nop_valid", {15'd0, ifid_valid}, 16'h0000);
    check("t5_addr_frozen", imem_addr, 16'h000C);
    pc_write_en = 1'b0;
    ifid_write_en = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    tick();
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    branch_taken = 1'b0;
    check("t5_no_stall_cnt", stall_cnt, 16'h0000);
    check("t5_no_branch", imem_addr, 16'h000C);
    check("t5_no_flush", flush_cnt, 16'h0000);

    // T5b HLT in branch shadow at 0012 is not latched
    mem[16'h000C >> 1] = 16'h2006;
    mem[16'h0012 >> 1] = 16'hF000;
    do_reset();
    tick(9);
    check("t5b_addr_pre", imem_addr, 16'h0012);
    branch_taken = 1'b1;
    branch_target = 16'h0030;
    tick();
    branch_taken = 1'b0;
    check("t5b_halted", {15'd0, halted}, 16'h0000);
    check("t5b_addr", imem_addr, 16'h0030);
    check("t5b_valid", {15'd0, ifid_valid}, 16'h0000);
    tick();
    check("t5b_halted2", {15'd0, halted}, 16'h0000);
    check("t5b_addr2", imem_addr, 16'h0032);
    mem[16'h0012 >> 1] = 16'h2009;

    // T6 PC wrap at FFFE
    do_reset();
    branch_taken = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    check("t6_addr_top", imem_addr, 16'hFFFE);
    tick();
    check("t6_wrap_addr", imem_addr, 16'h0000);
    check("t6_wrap_instr", ifid_instr, 16'h2FFF);
    check("t6_wrap_pp2", ifid_pc_plus2, 16'h0000);

    // T6 counter saturation on the narrow instance, exact count on the wide one
    do_reset();
    pc_write_en = 1'b0;
    ifid_write_en = 1'b0;
    tick(20);
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    check("t6_stall_sat", {12'd0, s_stall_cnt}, 16'h000F);
    check("t6_stall_wide", stall_cnt, 16'd20);
    branch_taken = 1'b1;
    branch_target = 16'h0200;
    tick(18);
    branch_taken = 1'b0;
    check("t6_flush_sat", {12'd0, s_flush_cnt}, 16'h000F);
    check("t6_flush_wide", flush_cnt, 16'd18);
    check("t6_stall_sat_hold", {12'd0, s_stall_cnt}, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
